// File: rtl/pipe_mux_reg.sv
// N-input operand select feeding a stallable, flushable register pipeline.
// Each stage carries {data, valid, err}; the outputs are the last stage.
module pipe_mux_reg #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 2,
  parameter int DEPTH = 1,
  localparam int SELW = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NSRC*WIDTH-1:0]   in_data,
  input  logic [SELW-1:0]         sel,
  input  logic                    in_valid,
  input  logic                    stall,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic                    out_sel_err
);

  logic [WIDTH-1:0] sel_data;
  logic             sel_hit;

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] err_q, err_d;

  // An out-of-range index matches no source, leaving data at zero and raising err.
  always_comb begin
    sel_data = '0;
    sel_hit  = 1'b0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      if (sel == SELW'(k)) begin
        sel_data = in_data[k*WIDTH +: WIDTH];
        sel_hit  = 1'b1;
      end
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    err_d   = err_q;
    if (flush) begin
      valid_d = '0;
      err_d   = '0;
    end else if (!stall) begin
      data_d[0]  = sel_data;
      valid_d[0] = in_valid;
      err_d[0]   = ~sel_hit & in_valid;
      for (int unsigned s = 1; s < DEPTH; s++) begin
        data_d[s]  = data_q[s-1];
        valid_d[s] = valid_q[s-1];
        err_d[s]   = err_q[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      err_q   <= '0;
      for (int unsigned s = 0; s < DEPTH; s++) begin
        data_q[s] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  assign out_data    = data_q[DEPTH-1];
  assign out_valid   = valid_q[DEPTH-1];
  assign out_sel_err = err_q[DEPTH-1];

endmodule
